// File: rtl/cur_fetch_pkg.sv
// rtl/cur_fetch_pkg.sv - state encoding and buffer geometry shared by the current-block fetch sequencer
package cur_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL0,
    ST_RUN,
    ST_SWITCH,
    ST_TRANS,
    ST_DRAIN
  } state_t;

  localparam int WORDS_PER_HALF = 16;
  localparam int BUF_WORDS      = 32;
  localparam int TRANS_CYCLES   = 8;

endpackage

// File: rtl/cur_fetch_req.sv
// rtl/cur_fetch_req.sv - fills one buffer half: issue/receive counters, outstanding-read limit, address generation
module cur_fetch_req
  import cur_fetch_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch,
  input  logic [ADDR_W-1:0] blk_base,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              read_en,
  output logic              fill_done
);

  // counters run 0..WORDS_PER_HALF inclusive, so they need one bit more than a half index
  localparam int CNT_W = $clog2(BUF_WORDS);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(WORDS_PER_HALF);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(WORDS_PER_HALF - 1);
  localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic              active;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [CNT_W-1:0]  outst;
  logic [ADDR_W-1:0] base_r;

  assign outst     = issue_cnt - rcv_cnt;
  assign mem_req   = active && (issue_cnt < HALF) && (outst < OUTST_LIM);
  assign mem_addr  = base_r + ADDR_W'(issue_cnt);
  assign read_en   = active && mem_rvalid;
  assign fill_done = read_en && (rcv_cnt == LAST);

  // launch wins over fill_done so a prefetch can start on the edge the previous fill ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      base_r    <= '0;
    end else if (launch) begin
      active    <= 1'b1;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      base_r    <= blk_base;
    end else if (fill_done) begin
      active    <= 1'b0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else begin
      if (mem_req && mem_gnt) issue_cnt <= issue_cnt + ONE;
      if (read_en)            rcv_cnt   <= rcv_cnt + ONE;
    end
  end

endmodule

// File: rtl/cur_fetch_ctrl.sv
// rtl/cur_fetch_ctrl.sv - current-block double-buffer sequencer; CUR_FETCH_PERF_EN builds the perf_stall counter
module cur_fetch_ctrl
  import cur_fetch_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BLK_W     = 10,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [BLK_W-1:0]  num_blocks,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  output logic              read_en,
  output logic              next_block,
  output logic              blk_valid,
  output logic [BLK_W-1:0]  blk_idx,
  input  logic              blk_done,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       perf_stall
);

  localparam int TW = $clog2(TRANS_CYCLES);
  localparam logic [TW-1:0] TRANS_LAST = TW'(TRANS_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_r, pf_base, launch_base;
  logic [BLK_W-1:0]  num_r;
  logic [BLK_W:0]    next_idx;
  logic [TW-1:0]     trans_cnt;
  logic              has_next, launch, fill_done, pf_ready, pf_ok, done_seen, done_hit;

  assign next_idx   = {1'b0, blk_idx} + (BLK_W+1)'(1);
  assign has_next   = next_idx < {1'b0, num_r};
  assign pf_base    = base_r + ADDR_W'(next_idx * WORDS_PER_HALF);
  assign done_hit   = (state == ST_RUN) && blk_valid && blk_done;
  assign pf_ok      = pf_ready || fill_done;
  assign busy       = (state != ST_IDLE);
  assign next_block = (state == ST_SWITCH);

  cur_fetch_req #(.ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST)) u_req (
    .clk        (clk),
    .rst        (rst),
    .launch     (launch),
    .blk_base   (launch_base),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .read_en    (read_en),
    .fill_done  (fill_done)
  );

  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    launch_base = pf_base;
    case (state)
      ST_IDLE: if (start && num_blocks != '0) begin
        state_nxt   = ST_FILL0;
        launch      = 1'b1;
        launch_base = base_addr;
      end
      ST_FILL0: if (fill_done) begin
        state_nxt = ST_RUN;
        launch    = has_next;
      end
      ST_RUN: begin
        if (done_hit && !has_next)                 state_nxt = ST_DRAIN;
        else if ((done_hit || done_seen) && pf_ok) state_nxt = ST_SWITCH;
      end
      ST_SWITCH: state_nxt = ST_TRANS;
      // blk_idx already points at the newly displayed block, so has_next looks one further
      ST_TRANS: if (trans_cnt == TRANS_LAST) begin
        state_nxt = ST_RUN;
        launch    = has_next;
      end
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r     <= '0;
      num_r      <= '0;
      blk_idx    <= '0;
      blk_valid  <= 1'b0;
      pf_ready   <= 1'b0;
      done_seen  <= 1'b0;
      trans_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_IDLE && start && num_blocks == '0) || (state_nxt == ST_DRAIN);
      if (state == ST_IDLE && start) begin
        base_r  <= base_addr;
        num_r   <= num_blocks;
        blk_idx <= '0;
      end else if (state == ST_SWITCH) begin
        blk_idx <= blk_idx + BLK_W'(1);
      end
      if (state != ST_RUN && state_nxt == ST_RUN) blk_valid <= 1'b1;
      else if (done_hit)                          blk_valid <= 1'b0;
      if (state_nxt != ST_RUN) done_seen <= 1'b0;
      else if (done_hit)       done_seen <= 1'b1;
      if (launch || state == ST_SWITCH)      pf_ready <= 1'b0;
      else if (state == ST_RUN && fill_done) pf_ready <= 1'b1;
      trans_cnt <= (state == ST_TRANS) ? trans_cnt + TW'(1) : '0;
    end
  end

`ifdef CUR_FETCH_PERF_EN
  logic [31:0] stall_cnt;

  // counts engine-idle cycles: block finished but the next half is still filling
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cnt <= '0;
    else if (state == ST_IDLE && start)       stall_cnt <= '0;
    else if (state == ST_RUN && done_seen && !pf_ok && stall_cnt != '1)
                                              stall_cnt <= stall_cnt + 32'd1;
  end

  assign perf_stall = stall_cnt;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_cur_fetch_ctrl.sv
// tb/tb_cur_fetch_ctrl.sv - self-checking bench for cur_fetch_ctrl with in-order latency memory and engine model
module tb_cur_fetch_ctrl;
  localparam int ADDR_W = 16, BLK_W = 10, MAX_OUTST = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0, blk_done = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [BLK_W-1:0]  num_blocks = '0;
  logic              mem_req, read_en, next_block, blk_valid, busy, frame_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  blk_idx;
  logic [31:0]       perf_stall;

  cur_fetch_ctrl #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .read_en(read_en), .next_block(next_block), .blk_valid(blk_valid), .blk_idx(blk_idx),
    .blk_done(blk_done), .busy(busy), .frame_done(frame_done), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // environment knobs
  int lat = 1, dly = 5;
  bit gnt_rand = 0, noise = 0, stray = 0;

  // reference model state: expected frame and observed event times
  logic [ADDR_W-1:0] exp_base;
  int exp_n;
  int issued, rcvd, outst_max, nb_cnt, fd_cnt, fd_cyc, rise_cnt, rise_bad, addr_bad, rd_bad, stall_exp;
  int f_cyc[64], d_cyc[64], first_iss[64];
  bit prev_valid = 0, prev_nb = 0, real_rsp = 0;
  int pend[$];
  int vcnt = 0;

  task automatic clear_stats();
    issued = 0; rcvd = 0; outst_max = 0; nb_cnt = 0; fd_cnt = 0; fd_cyc = -1;
    rise_cnt = 0; rise_bad = 0; addr_bad = 0; rd_bad = 0; stall_exp = 0;
    for (int i = 0; i < 64; i++) begin
      f_cyc[i] = -1000; d_cyc[i] = -1000; first_iss[i] = -1;
    end
  endtask

  // memory, engine and monitor: drive at negedge, observe 1 time unit later
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      mem_rvalid = 1'b0; mem_gnt = 1'b0; blk_done = 1'b0; vcnt = 0; real_rsp = 0;
    end else begin
      mem_gnt  = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      real_rsp = 0;
      if (pend.size() > 0 && pend[0] <= cyc) begin
        void'(pend.pop_front());
        real_rsp = 1;
      end
      mem_rvalid = real_rsp || stray;
      blk_done   = blk_valid ? (vcnt == dly) : (noise && $urandom_range(0, 3) == 0);
      vcnt       = blk_valid ? vcnt + 1 : 0;
      #1;
      if (blk_valid && !prev_valid) begin
        int k, expv;
        k = rise_cnt;
        if (int'(blk_idx) != k) rise_bad++;
        if (rcvd < 16 * (k + 1)) rise_bad++;
        if (k == 0) expv = f_cyc[0] + 1;
        else begin
          expv = ((d_cyc[k-1] > f_cyc[k]) ? d_cyc[k-1] : f_cyc[k]) + 10;
          if (f_cyc[k] > d_cyc[k-1]) stall_exp += f_cyc[k] - d_cyc[k-1] - 1;
        end
        if (cyc != expv) rise_bad++;
        rise_cnt++;
      end
      prev_valid = blk_valid;
      if (blk_done && blk_valid && rise_cnt > 0 && rise_cnt <= 64) d_cyc[rise_cnt-1] = cyc;
      if (mem_req && mem_gnt) begin
        logic [ADDR_W-1:0] ea;
        ea = exp_base + ADDR_W'(issued);
        if (issued >= exp_n * 16 || mem_addr !== ea) addr_bad++;
        if (issued % 16 == 0 && issued / 16 < 64) begin
          first_iss[issued/16] = cyc;
          if (rise_cnt < issued / 16) rise_bad++;
        end
        issued++;
        pend.push_back(cyc + lat);
      end
      if (read_en !== real_rsp) rd_bad++;
      if (read_en) begin
        rcvd++;
        if (rcvd % 16 == 0 && rcvd / 16 <= 64) f_cyc[rcvd/16-1] = cyc;
      end
      if (issued - rcvd > outst_max) outst_max = issued - rcvd;
      if (next_block) begin
        nb_cnt++;
        if (prev_nb) rise_bad++;
      end
      prev_nb = next_block;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic begin_frame(input int n, input int base, input int l, input int d, input bit g,
                             output int s);
    @(negedge clk);
    clear_stats();
    lat = l; dly = d; gnt_rand = g;
    exp_base = ADDR_W'(base); exp_n = n;
    base_addr = ADDR_W'(base); num_blocks = BLK_W'(n);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input int base, input int l, input int d,
                           input bit g, input int exp_reads, input int exp_nb);
    int s;
    begin_frame(n, base, l, d, g, s);
    for (int i = 0; i < 20000 && fd_cnt == 0; i++) begin
      @(negedge clk);
      if (n > 0 && i == 10) begin start = 1'b1; num_blocks = BLK_W'(7); base_addr = 16'h5555; end
      if (i == 11) start = 1'b0;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check({tag, " frame_done_count"}, fd_cnt, 1);
    check({tag, " frame_done_cycle"}, fd_cyc, (n == 0) ? s + 1 : d_cyc[n-1] + 1);
    check({tag, " reads_issued"}, issued, exp_reads);
    check({tag, " read_en_count"}, rcvd, exp_reads);
    check({tag, " next_block_count"}, nb_cnt, exp_nb);
    check({tag, " blocks_displayed"}, rise_cnt, n);
    check({tag, " display_timing_errs"}, rise_bad, 0);
    check({tag, " addr_errs"}, addr_bad, 0);
    check({tag, " read_en_errs"}, rd_bad, 0);
    check({tag, " outstanding_ok"}, int'(outst_max <= MAX_OUTST), 1);
    check({tag, " busy_after"}, int'(busy), 0);
    if (n > 0 && !g) check({tag, " first_req_latency"}, first_iss[0] - s, 1);
`ifdef CUR_FETCH_PERF_EN
    check({tag, " perf_stall"}, int'(perf_stall), stall_exp);
`else
    check({tag, " perf_stall"}, int'(perf_stall), 0);
`endif
    if (fd_cnt == 0) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " strobes"}, int'({mem_req, read_en, next_block, blk_valid, busy, frame_done}), 0);
    check({tag, " mem_addr"}, int'(mem_addr), 0);
    check({tag, " blk_idx"}, int'(blk_idx), 0);
    check({tag, " perf_stall"}, int'(perf_stall), 0);
  endtask

  typedef struct {
    int n; int base; int lat; int dly; bit grnd; int exp_reads; int exp_nb;
  } vec_t;

  initial begin
    vec_t vt[5];
    int s, bad;
    vt[0] = '{1, 'h0100, 1,  5, 0, 16, 0};
    vt[1] = '{3, 'h2000, 1, 40, 0, 48, 2};
    vt[2] = '{2, 'h0040, 20, 3, 0, 32, 1};
    vt[3] = '{4, 'hFFE0, 3,  0, 1, 64, 3};
    vt[4] = '{0, 'h0300, 1,  5, 0,  0, 0};

    repeat (3) @(negedge clk);
    #2 check_idle("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vt[i].n, vt[i].base, vt[i].lat, vt[i].dly, vt[i].grnd,
                vt[i].exp_reads, vt[i].exp_nb);

    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(1, 5);
      noise = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", i), n, $urandom_range(0, 16'hFFFF), $urandom_range(1, 12),
                $urandom_range(0, 30), 1'($urandom_range(0, 1)), 16 * n, n - 1);
    end
    noise = 0;

    // abort mid-fill of block 1, then stray read data while idle
    begin_frame(3, 'h3000, 4, 60, 0, s);
    for (int i = 0; i < 500 && rcvd < 20; i++) @(negedge clk);
    check("abort reached block1 fill", int'(rcvd >= 20 && rcvd < 32), 1);
    #2 rst = 1'b1;
    #1 check_idle("async_reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    stray = 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2 if (read_en || mem_req || busy) bad++;
    end
    stray = 0;
    check("stray_rvalid_dropped", bad, 0);
    run_frame("after_reset", 2, 'h0800, 2, 10, 0, 32, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
